// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first a/b streams in, registered difference bit out,
// with the parallel result and final borrow assembled over one WIDTH-bit frame.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    output logic             diff,
    output logic             diff_valid,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic            borrow;
    logic [CW-1:0]   count;

    logic            diff_new;
    logic            borrow_new;
    logic            last_bit;
    logic            first_bit;

    // Full-subtractor cell fed by the running borrow.
    assign diff_new   = a ^ b ^ borrow;
    assign borrow_new = (~a & b) | (~(a ^ b) & borrow);
    assign last_bit   = (count == CW'(WIDTH - 1));
    assign first_bit  = (count == '0);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking assignments would make update order matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            borrow     <= 1'b0;
            count      <= '0;
            diff       <= 1'b0;
            diff_valid <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            diff_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        borrow <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        diff       <= diff_new;
                        diff_valid <= 1'b1;
                        borrow     <= borrow_new;
                        // The first bit of a frame discards the previous frame's result.
                        if (first_bit)
                            result <= {diff_new, {(WIDTH-1){1'b0}}};
                        else
                            result <= {diff_new, result[WIDTH-1:1]};
                        if (last_bit) begin
                            borrow_out <= borrow_new;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a driver pushes expected bits/frames
// from plain (a - b) arithmetic; a negedge monitor pops and compares them.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         a = 1'b0;
    logic         b = 1'b0;
    logic         diff;
    logic         diff_valid;
    logic [W-1:0] result;
    logic         borrow_out;
    logic         busy;
    logic         done;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .diff_valid (diff_valid),
        .result     (result),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         bo;
    } frame_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    frame_t       exp_frames[$];
    logic         exp_bits[$];
    logic [W-1:0] prev_res = '0;
    logic         prev_bo = 1'b0;
    logic         last_diff = 1'b0;
    frame_t       mon_frame;
    logic         mon_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_diff"}, {31'b0, diff}, 0);
        check({tag, "_diff_valid"}, {31'b0, diff_valid}, 0);
        check({tag, "_result"}, {24'b0, result}, 0);
        check({tag, "_borrow_out"}, {31'b0, borrow_out}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_done"}, {31'b0, done}, 0);
    endtask

    // Monitor: consumes one expected bit per diff_valid and one frame per done.
    always @(negedge clk) begin
        if (rst) begin
            if (diff_valid) begin
                if (exp_bits.size() == 0) begin
                    check("spurious_diff_valid", {31'b0, diff_valid}, 0);
                end else begin
                    mon_bit = exp_bits.pop_front();
                    check("diff_bit", {31'b0, diff}, {31'b0, mon_bit});
                end
            end
            if (done) begin
                if (exp_frames.size() == 0) begin
                    check("spurious_done", {31'b0, done}, 0);
                end else begin
                    mon_frame = exp_frames.pop_front();
                    check("result", {24'b0, result}, {24'b0, mon_frame.res});
                    check("borrow_out", {31'b0, borrow_out}, {31'b0, mon_frame.bo});
                    check("bits_outstanding", exp_bits.size(), 0);
                end
            end
        end
    end

    // Drives one frame from an IDLE drive point. stall_mask bit c stalls RUN cycle c;
    // noise toggles start during RUN/DONE; rst_after>0 resets after that many bits.
    task automatic run_frame(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [31:0] stall_mask, input bit noise,
                             input int rst_after);
        frame_t     f;
        logic [W:0] d;
        int         c;
        int         nb;
        d     = {1'b0, av} - {1'b0, bv};
        f.res = d[W-1:0];
        f.bo  = d[W];
        exp_frames.push_back(f);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 1);
        check("result_held", {24'b0, result}, {24'b0, prev_res});
        check("borrow_held", {31'b0, borrow_out}, {31'b0, prev_bo});
        c  = 0;
        nb = 0;
        while (nb < W) begin
            start = noise ? 1'($urandom) : 1'b0;
            if (c < 32 && stall_mask[c]) begin
                in_valid = 1'b0;
                a = 1'($urandom);
                b = 1'($urandom);
                @(posedge clk); #1;
                check("stall_diff_valid", {31'b0, diff_valid}, 0);
                check("stall_busy", {31'b0, busy}, 1);
                check("stall_diff_hold", {31'b0, diff}, {31'b0, last_diff});
            end else begin
                in_valid = 1'b1;
                a = av[nb];
                b = bv[nb];
                exp_bits.push_back(f.res[nb]);
                last_diff = f.res[nb];
                @(posedge clk); #1;
                nb++;
                check("busy_run", {31'b0, busy}, (nb < W) ? 1 : 0);
                if (rst_after == nb) begin
                    rst      = 1'b0;
                    in_valid = 1'b0;
                    start    = 1'b0;
                    #1;
                    check_all_zero("midframe_reset");
                    exp_frames.delete();
                    exp_bits.delete();
                    repeat (3) @(posedge clk);
                    #1;
                    check("reset_no_done", {31'b0, done}, 0);
                    rst       = 1'b1;
                    prev_res  = '0;
                    prev_bo   = 1'b0;
                    last_diff = 1'b0;
                    return;
                end
            end
            c++;
        end
        in_valid = 1'b0;
        start    = noise;
        check("done_timing", {31'b0, done}, 1);
        check("done_busy_low", {31'b0, busy}, 0);
        check("done_result", {24'b0, result}, {24'b0, f.res});
        prev_res = f.res;
        prev_bo  = f.bo;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", {31'b0, done}, 0);
        check("idle_busy", {31'b0, busy}, 0);
        if (noise) begin
            @(posedge clk); #1;
            check("start_in_done_ignored", {31'b0, busy}, 0);
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        run_frame(8'h05, 8'h03, 32'h0, 1'b0, -1);
        run_frame(8'h03, 8'h05, 32'h0, 1'b0, -1);
        run_frame(8'hFF, 8'h01, 32'h0, 1'b0, -1);
        run_frame(8'h00, 8'h00, 32'h0, 1'b0, -1);
        run_frame(8'h80, 8'h01, 32'h26, 1'b0, -1);
        run_frame(8'h5A, 8'h3C, 32'h0, 1'b1, -1);
        run_frame(8'h37, 8'h12, 32'h0, 1'b0, 4);
        run_frame(8'h10, 8'h20, 32'h0, 1'b0, -1);
        run_frame(8'hC3, 8'hC3, 32'h0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            run_frame(8'($urandom), 8'($urandom), $urandom & 32'h0000_0A49,
                      1'($urandom), -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("frames_outstanding", exp_frames.size(), 0);
        check("bits_left_at_end", exp_bits.size(), 0);
        check("final_idle_busy", {31'b0, busy}, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
